// File: rtl/serial_frame_rx.sv
// Serial frame receiver: SYNC_LEN ones, then DATA_W bits MSB first (+even parity bit under SFR_PARITY_EN).
// Latency: data_out/frame_valid/parity_err registered on the edge that samples the final bit.
// Backpressure: none; bits are consumed only on sample_en strobes and all state holds otherwise.
module serial_frame_rx #(
  parameter int DATA_W   = 32,
  parameter int SYNC_LEN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_valid,
  output logic              busy,
  output logic              parity_err
);
  localparam int SC_W = $clog2(SYNC_LEN + 1);
  localparam int BC_W = $clog2(DATA_W);

`ifdef SFR_PARITY_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

  state_t            state, state_nxt;
  logic [SC_W-1:0]   sync_cnt, sync_cnt_nxt;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [DATA_W-1:0] data_out_nxt;
  logic              frame_valid_nxt;
`ifdef SFR_PARITY_EN
  logic              parity_err_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sync_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_out    <= '0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      sync_cnt    <= sync_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shreg       <= shreg_nxt;
      data_out    <= data_out_nxt;
      frame_valid <= frame_valid_nxt;
    end
  end

`ifdef SFR_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= parity_err_nxt;
  end
`else
  assign parity_err = 1'b0;
`endif

  // Pulses default low every clk so they stay one cycle wide under any strobe spacing.
  always_comb begin
    state_nxt       = state;
    sync_cnt_nxt    = sync_cnt;
    bit_cnt_nxt     = bit_cnt;
    shreg_nxt       = shreg;
    data_out_nxt    = data_out;
    frame_valid_nxt = 1'b0;
`ifdef SFR_PARITY_EN
    parity_err_nxt  = 1'b0;
`endif
    if (sample_en) begin
      case (state)
        IDLE: begin
          if (data_in) begin
            state_nxt    = SYNC;
            sync_cnt_nxt = SC_W'(1);
          end
        end
        SYNC: begin
          if (!data_in) begin
            state_nxt    = IDLE;
            sync_cnt_nxt = '0;
          end else if (sync_cnt == SC_W'(SYNC_LEN - 1)) begin
            state_nxt    = DATA;
            sync_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
          end else begin
            sync_cnt_nxt = sync_cnt + SC_W'(1);
          end
        end
        DATA: begin
          shreg_nxt   = {shreg[DATA_W-2:0], data_in};
          bit_cnt_nxt = bit_cnt + BC_W'(1);
          if (bit_cnt == BC_W'(DATA_W - 1)) begin
`ifdef SFR_PARITY_EN
            state_nxt       = PAR;
`else
            state_nxt       = IDLE;
            data_out_nxt    = shreg_nxt;
            frame_valid_nxt = 1'b1;
`endif
          end
        end
`ifdef SFR_PARITY_EN
        PAR: begin
          // Even parity: payload plus parity bit must hold an even number of ones.
          state_nxt = IDLE;
          if (!((^shreg) ^ data_in)) begin
            data_out_nxt    = shreg;
            frame_valid_nxt = 1'b1;
          end else begin
            parity_err_nxt  = 1'b1;
          end
        end
`endif
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: vector table, corner-case sequences and a random stream vs a frame-parsing model.
module tb_serial_frame_rx;
  localparam int DATA_W   = 32;
  localparam int SYNC_LEN = 2;
`ifdef SFR_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic              sample_en;
  logic              data_in;
  logic [DATA_W-1:0] data_out;
  logic              frame_valid;
  logic              busy;
  logic              parity_err;

  serial_frame_rx #(.DATA_W(DATA_W), .SYNC_LEN(SYNC_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .data_in     (data_in),
    .data_out    (data_out),
    .frame_valid (frame_valid),
    .busy        (busy),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]       pre;
    int                len;
    logic [DATA_W-1:0] pay;
    int                gap;
    logic [DATA_W-1:0] exp_out;
    logic              exp_vld;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int n_perr = 0;
  int exp_perr_total = 0;
  logic fv_prev = 1'b0;
  logic pe_prev = 1'b0;
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] exp_q[$];
  bit fb[$];
  bit rs[$];
  int exp_perr_rand;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        got_q.push_back(data_out);
        check("frame_valid_width", 64'(fv_prev), 64'(0));
      end
      if (parity_err) begin
        n_perr++;
        check("parity_err_width", 64'(pe_prev), 64'(0));
      end
    end
    fv_prev = frame_valid;
    pe_prev = parity_err;
  end

  // Called at #1 after a rising edge; returns at the same phase.
  task automatic send_bit(input bit b, input int gap);
    data_in   = b;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic build(input logic [15:0] pre, input int len, input logic [DATA_W-1:0] pay);
    fb.delete();
    for (int k = len - 1; k >= 0; k--) fb.push_back(pre[k]);
    for (int k = DATA_W - 1; k >= 0; k--) fb.push_back(pay[k]);
`ifdef SFR_PARITY_EN
    fb.push_back(^pay);
`endif
  endtask

  task automatic send_fb(input int gap);
    for (int k = 0; k < fb.size(); k++) send_bit(fb[k], (k == fb.size() - 1) ? 0 : gap);
  endtask

  // Reference: scan the bit stream; SYNC_LEN consecutive ones open a frame whose next
  // DATA_W (+parity) bits are taken verbatim, then scanning resumes after the frame.
  task automatic ref_frames();
    int i;
    int run;
    logic [DATA_W-1:0] w;
    exp_q.delete();
    exp_perr_rand = 0;
    i   = 0;
    run = 0;
    while (i < rs.size()) begin
      if (run < SYNC_LEN) begin
        run = rs[i] ? run + 1 : 0;
        i++;
      end else begin
        if (i + DATA_W + PAR_BITS > rs.size()) break;
        w = '0;
        for (int k = 0; k < DATA_W; k++) w = {w[DATA_W-2:0], 1'(rs[i+k])};
        if (PAR_BITS == 1 && (((^w) ^ rs[i+DATA_W]) == 1'b1)) exp_perr_rand++;
        else exp_q.push_back(w);
        i   = i + DATA_W + PAR_BITS;
        run = 0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int busy_bad;
    int perr_before;
    vecs[0] = '{16'b11,     2, 32'hA5A5_0F0F, 0, 32'hA5A5_0F0F, 1'b1};
    vecs[1] = '{16'b1011,   4, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{16'b11,     2, 32'h0000_0001, 0, 32'h0000_0001, 1'b1};
    vecs[3] = '{16'b0,      4, 32'h0000_0000, 0, 32'h0000_0001, 1'b0};
    vecs[4] = '{16'b11,     2, 32'h1234_5678, 3, 32'h1234_5678, 1'b1};
    vecs[5] = '{16'b010011, 6, 32'h0F0F_F0F0, 1, 32'h0F0F_F0F0, 1'b1};

    rst_n = 1'b0; sample_en = 1'b0; data_in = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      data_in   = ~data_in;
      sample_en = ~sample_en;
    end
    check("rst_data_out",    64'(data_out),    64'(0));
    check("rst_frame_valid", 64'(frame_valid), 64'(0));
    check("rst_busy",        64'(busy),        64'(0));
    check("rst_parity_err",  64'(parity_err),  64'(0));
    rst_n = 1'b1; sample_en = 1'b0; data_in = 1'b0;
    @(posedge clk); #1;

    // Vectors run back-to-back; each is checked on the cycle right after its last bit.
    for (int v = 0; v < 6; v++) begin
      build(vecs[v].pre, vecs[v].len, vecs[v].pay);
      send_fb(vecs[v].gap);
      check($sformatf("vec%0d_valid", v), 64'(frame_valid), 64'(vecs[v].exp_vld));
      check($sformatf("vec%0d_data", v),  64'(data_out),    64'(vecs[v].exp_out));
    end

    // Strobe every 4th clk; busy must stay high between the first and last strobed bit.
    build(16'b11, 2, 32'h1234_5678);
    busy_bad = 0;
    for (int k = 0; k < fb.size(); k++) begin
      send_bit(fb[k], (k == fb.size() - 1) ? 0 : 3);
      if (k < fb.size() - 1 && busy !== 1'b1) busy_bad++;
    end
    check("strobe_busy_drops", 64'(busy_bad),    64'(0));
    check("strobe_valid",      64'(frame_valid), 64'(1));
    check("strobe_data",       64'(data_out),    64'(32'h1234_5678));
    @(posedge clk); #1;
    check("strobe_valid_gone", 64'(frame_valid), 64'(0));
    check("strobe_busy_end",   64'(busy),        64'(0));

    // Reset after 10 payload bits, then a clean frame.
    build(16'b11, 2, 32'hDEAD_BEEF);
    for (int k = 0; k < 12; k++) send_bit(fb[k], 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data_out", 64'(data_out), 64'(0));
    check("midrst_busy",     64'(busy),     64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_fb(0);
    check("after_rst_valid", 64'(frame_valid), 64'(1));
    check("after_rst_data",  64'(data_out),    64'(32'hDEAD_BEEF));

`ifdef SFR_PARITY_EN
    build(16'b11, 2, 32'h0000_0003);
    fb[fb.size()-1] = 1'b0;
    send_fb(0);
    check("par_ok_valid", 64'(frame_valid), 64'(1));
    check("par_ok_data",  64'(data_out),    64'(32'h0000_0003));
    build(16'b11, 2, 32'h0000_0007);
    fb[fb.size()-1] = 1'b0;
    send_fb(0);
    exp_perr_total++;
    check("par_bad_err",   64'(parity_err),  64'(1));
    check("par_bad_valid", 64'(frame_valid), 64'(0));
    check("par_bad_data",  64'(data_out),    64'(32'h0000_0003));
`endif

    // Random stream with random strobe spacing against the parsing model.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    rs.delete();
    for (int k = 0; k < 1500; k++) rs.push_back(1'($urandom_range(0, 1)));
    ref_frames();
    perr_before = n_perr;
    for (int k = 0; k < rs.size(); k++) send_bit(rs[k], $urandom_range(0, 2));
    repeat (3) begin @(posedge clk); #1; end
    exp_perr_total += exp_perr_rand;
    check("rand_frame_count", 64'(got_q.size()), 64'(exp_q.size()));
    check("rand_perr_count",  64'(n_perr - perr_before), 64'(exp_perr_rand));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("rand_frame%0d", k), 64'(got_q[k]), 64'(exp_q[k]));
    check("total_parity_err", 64'(n_perr), 64'(exp_perr_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Parametrised serial-to-parallel frame receiver for the self-test datapath. It monitors a single-bit serial line for a run of SYNC_LEN consecutive ones, then shifts in DATA_W payload bits MSB first, qualified by a bit-rate strobe. It presents the completed word with a one-cycle valid pulse and holds it until the next good frame. It sits between the serial test link and the parallel self-test checker.

## Interface
- DATA_W, 32: payload width in bits; legal range 2..64.
- SYNC_LEN, 2: number of consecutive 1 bits that form the sync preamble; legal range 2..8.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset: asynchronous assert, active-low.
- sample_en  input  1  bit strobe; data_in is sampled only on edges where sample_en=1.
- data_in  input  1  serial line.
- data_out  output  DATA_W  last good frame payload; reset 0.
- frame_valid  output  1  one-clk pulse when data_out is updated; reset 0.
- busy  output  1  1 while in SYNC, DATA or PAR state; reset 0.
- parity_err  output  1  one-clk pulse on a parity failure (SFR_PARITY_EN only, else constant 0); reset 0.

## Operation
- FSM states: IDLE, SYNC, DATA, PAR (PAR exists only with SFR_PARITY_EN). sync_cnt is clog2(SYNC_LEN+1) bits wide; bit_cnt is clog2(DATA_W) bits wide; the payload shift register is shreg[DATA_W-1:0].
- The FSM, the counters and shreg change only on edges where sample_en=1. When sample_en=0, all state holds.
- IDLE: data_in=1 -> SYNC with sync_cnt=1. data_in=0 -> stay in IDLE.
- SYNC: data_in=0 -> IDLE, sync_cnt=0. data_in=1 with sync_cnt=SYNC_LEN-1 -> DATA with bit_cnt=0. Otherwise sync_cnt++.
- DATA: shreg <= {shreg[DATA_W-2:0], data_in} and bit_cnt++. When the bit at bit_cnt=DATA_W-1 is sampled:
  - with SFR_PARITY_EN, go to PAR;
  - without it, data_out <= the new shreg value, frame_valid pulses, go to IDLE.
- Payload bits are not inspected for sync, so ones inside the payload never restart the frame.
- PAR: sample the parity bit; even parity is checked over the payload plus the parity bit.
  - Pass: data_out updated, frame_valid pulses.
  - Fail: data_out unchanged, parity_err pulses, frame_valid stays 0.
  - Either way, go to IDLE.
- data_out holds its value across any number of failed, aborted or partial frames.
- busy = (state != IDLE).

## Timing
- Frame length on the line: SYNC_LEN + DATA_W (+1 with parity) strobed bits.
- Latency: data_out and frame_valid (or parity_err) are registered on the same edge that samples the final bit; they are visible in the following cycle.
- frame_valid and parity_err are exactly one clk wide, regardless of sample_en spacing.
- Back-to-back frames: the FSM is back in IDLE after the final bit. The next strobed bit can be the first sync bit of a new frame, with zero gap.
- sample_en held at 1 continuously: one bit per clk.
- Reset mid-frame: rst_n low clears all state, counters, shreg and outputs immediately. After release, the receiver waits in IDLE for a fresh sync.
- Sync abort: a 0 in SYNC returns to IDLE on that edge. The following strobed bit is evaluated as an IDLE bit.

## Configuration
- SFR_PARITY_EN defined: a trailing even-parity bit follows the payload, the PAR state is present, bad frames are dropped, and parity_err is live.
- SFR_PARITY_EN undefined: no parity bit, no PAR state, and parity_err is tied to 0.

## Test plan
- Reset: hold rst_n=0, toggle data_in -> data_out=0, frame_valid=0, busy=0, parity_err=0.
- Basic frame: DATA_W=32, sample_en=1, send 1,1 then 0xA5A5_0F0F MSB first -> data_out=0xA5A5_0F0F; frame_valid pulses once, 1 clk after bit 34 is sampled.
- Sync abort and payload ones: send 1,0,1,1 then 0xFFFF_FFFF -> the first 1 is discarded and data_out=0xFFFF_FFFF. Next, send 1,1 followed by 0x0000_0001, back-to-back -> data_out=0x0000_0001 with two separate frame_valid pulses.
- Strobed rate: sample_en=1 every 4th clk, frame 0x1234_5678, data_in changing only on strobe cycles -> data_out=0x1234_5678; frame_valid is 1 clk wide; busy is high for all 34 strobed bits.
- Reset mid-frame: assert rst_n after 10 payload bits, release, send a full frame 0xDEAD_BEEF -> no stale data; data_out=0xDEAD_BEEF.
- Parity (SFR_PARITY_EN): 0x0000_0003 with parity bit 0 -> frame_valid pulses, data_out=0x0000_0003. Then 0x0000_0007 with parity bit 0 -> parity_err pulses, data_out stays 0x0000_0003.
